sklansky_approx_pipe: RTL
=========================

SKLANSKY_APPROX_PIPE -- requirements
Module: sklansky_approx_pipe

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits; legal range 4..64.
REQ-002 Parameter K, default 4: approximated low-order bits; legal range 0..WIDTH-1.
REQ-003 Parameter CNT_W, default 16: width of the error counter.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1: synchronous active-high reset.
REQ-007 Port in_valid, input, 1: operands are presented.
REQ-008 Port in_ready, output, 1: the block can accept operands.
REQ-009 Port a, input, WIDTH: operand A.
REQ-010 Port b, input, WIDTH: operand B.
REQ-011 Port cin, input, 1: carry-in; used only in exact mode.
REQ-012 Port approx_en, input, 1: 1 = approximate mode, 0 = exact mode; sampled per transaction.
REQ-013 Port out_valid, output, 1: the result is valid.
REQ-014 Port out_ready, input, 1: downstream accepts the result.
REQ-015 Port sum, output, WIDTH: result sum.
REQ-016 Port cout, output, 1: carry out of the MSB.
REQ-017 Port err_cnt, output, CNT_W: count of approximate transactions whose result differed from the exact result.
REQ-018 Port cnt_clr, input, 1: synchronous clear of err_cnt.

Function
REQ-019 Exact mode SHALL produce {cout,sum} = a + b + cin, computed with a Sklansky parallel-prefix carry tree of ceil(log2 WIDTH) levels.
REQ-020 Approximate mode SHALL ignore cin and compute the low bits as follows:
- sum[0] = a[0]^b[0];
- sum[i] = (a[i-1]&b[i-1]) ^ a[i] ^ b[i] for 1 <= i <= K-1.
REQ-021 Approximate mode SHALL use carry-in to bit K = a[K-1]&b[K-1], and {cout, sum[WIDTH-1:K]} SHALL be the exact prefix sum of the upper operand slices plus that carry.
REQ-022 With K=0, approximate mode SHALL equal exact mode with cin forced to 0.
REQ-023 The pipeline SHALL have two register stages:
- S1 registers a, b, cin, approx_en, and the level-1 propagate/generate terms;
- S2 registers sum, cout, and a mismatch flag.
Latency from handshake acceptance to out_valid is 2 cycles.
REQ-024 Input transfer SHALL occur when in_valid&in_ready; output transfer SHALL occur when out_valid&out_ready.
REQ-025 Flow control SHALL be:
- S2 advances when !out_valid | out_ready;
- S1 advances when S1 is empty or S2 advances;
- in_ready = !s1_valid | S2 advances.
REQ-026 Under stall, S1 and S2 contents and out_valid SHALL hold unchanged; no transaction is dropped or duplicated, and order is preserved.
REQ-027 Full throughput of one transaction per cycle SHALL be sustained while out_ready=1.
REQ-028 The mismatch flag SHALL be set when approx_en=1 and {cout,sum} differs from the exact a+b (cin ignored); it SHALL be 0 in exact mode.
REQ-029 err_cnt SHALL increment by 1 on each output transfer whose mismatch flag is set, and SHALL saturate at 2^CNT_W-1.
REQ-030 cnt_clr SHALL set err_cnt to 0 on the next edge and has priority over a same-cycle increment.
REQ-031 A change of approx_en between transactions SHALL affect only newly accepted transactions.

Reset
REQ-032 While rst=1, on each edge:
- s1_valid, out_valid = 0;
- sum, cout = 0;
- err_cnt = 0.
REQ-033 in_ready SHALL be 0 while rst=1 and 1 on the first cycle after rst falls.
REQ-034 Reset mid-operation SHALL discard all in-flight transactions; no out_valid SHALL appear for them.

Verification (WIDTH=16, K=4)
REQ-035 Approximate miss: approx_en=1, a=0x000F, b=0x0001 -> 2 cycles later sum=0x000C, cout=0, and err_cnt goes 0->1 on transfer.
REQ-036 Approximate hit: approx_en=1, a=0x0008, b=0x0008 -> sum=0x0010, cout=0, err_cnt unchanged.
REQ-037 Exact mode with carry: approx_en=0, a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, no err_cnt increment. Back-to-back random exact vectors SHALL match a+b+cin at one result per cycle.
REQ-038 Backpressure:
- hold out_ready=0 and present 3 transactions -> two accepted, in_ready=0 on the third;
- raise out_ready -> results emerge in order, none lost.
REQ-039 Reset and counter control:
- assert rst with both stages full -> out_valid=0 the next cycle and err_cnt=0;
- with err_cnt at 0xFFFF, a further mismatch -> err_cnt stays 0xFFFF;
- cnt_clr concurrent with a mismatch transfer -> err_cnt=0.

Source files
------------

// File: rtl/sklansky_approx_pipe.sv
// Two-stage pipelined adder built on a Sklansky parallel-prefix carry tree,
// with an optional approximate mode for the low K bits and a mismatch counter.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   in_valid/ready  - operand handshake (a, b, cin, approx_en)
//   out_valid/ready - result handshake (sum, cout)
//   approx_en       - 1: approximate low K bits, cin ignored; 0: exact a+b+cin
//   err_cnt         - saturating count of delivered approximate results that
//                     differ from exact a+b
//   cnt_clr         - synchronous clear of err_cnt (wins over an increment)
module sklansky_approx_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned K     = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             cnt_clr
);

  localparam int unsigned LVLS = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Sklansky prefix adder over bitwise propagate/generate; returns {cout, sum}.
  // The carry-in is folded into bit 0's generate so the tree needs no extra column.
  function automatic logic [WIDTH:0] prefix_add(input logic [WIDTH-1:0] p,
                                                input logic [WIDTH-1:0] g,
                                                input logic             c0);
    logic [WIDTH-1:0] gg;
    logic [WIDTH-1:0] pp;
    logic [WIDTH-1:0] s;
    int               j;
    gg    = g;
    pp    = p;
    gg[0] = g[0] | (p[0] & c0);
    for (int l = 0; l < int'(LVLS); l++) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (((i >> l) & 1) == 1) begin
          // Last index of the lower half of this block; untouched at this level.
          j     = ((i >> l) << l) - 1;
          gg[i] = gg[i] | (pp[i] & gg[j]);
          pp[i] = pp[i] & pp[j];
        end
      end
    end
    s[0] = p[0] ^ c0;
    for (int i = 1; i < int'(WIDTH); i++) begin
      s[i] = p[i] ^ gg[i-1];
    end
    return {gg[WIDTH-1], s};
  endfunction

  // Handshake / stage-advance conditions
  logic s1_valid_q;
  logic out_valid_q;
  logic s2_adv_c;
  logic s1_adv_c;
  logic accept_c;

  always_comb begin
    s2_adv_c = !out_valid_q || out_ready;
    s1_adv_c = !s1_valid_q || s2_adv_c;
    accept_c = in_valid && s1_adv_c && !rst;
  end

  assign in_ready = s1_adv_c && !rst;

  // Stage 1: operands, mode and level-1 propagate/generate
  logic [WIDTH-1:0] a_q, b_q, p_q, g_q;
  logic [WIDTH-1:0] p_d, g_d;
  logic             cin_q, apx_q;

  always_comb begin
    p_d = a ^ b;
    g_d = a & b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else if (s1_adv_c) begin
      s1_valid_q <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_c) begin
      a_q   <= a;
      b_q   <= b;
      cin_q <= cin;
      apx_q <= approx_en;
      p_q   <= p_d;
      g_q   <= g_d;
    end
  end

  // Stage 2 datapath: one shared tree; in approximate mode the low slice is
  // masked so the only carry reaching bit K is a[K-1]&b[K-1].
  logic [WIDTH-1:0] pt_c, gt_c;
  logic             c0_c;
  logic [WIDTH:0]   res_d;
  logic [WIDTH:0]   exact_c;
  logic             mism_d;

  always_comb begin
    pt_c = p_q;
    gt_c = g_q;
    c0_c = cin_q;
    if (apx_q) begin
      c0_c = 1'b0;
      for (int i = 0; i < int'(K); i++) begin
        pt_c[i] = 1'b0;
        if (i + 1 != int'(K)) gt_c[i] = 1'b0;
      end
    end
    res_d = prefix_add(pt_c, gt_c, c0_c);
    if (apx_q) begin
      if (K > 0) res_d[0] = p_q[0];
      for (int i = 1; i < int'(K); i++) begin
        res_d[i] = g_q[i-1] ^ p_q[i];
      end
    end
    exact_c = {1'b0, a_q} + {1'b0, b_q};
    mism_d  = apx_q && (res_d != exact_c);
  end

  // Stage 2 registers
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             mism_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      mism_q      <= 1'b0;
    end else if (s2_adv_c) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        {cout_q, sum_q} <= res_d;
        mism_q          <= mism_d;
      end
    end
  end

  // Saturating mismatch counter, bumped on delivered mismatching results
  logic [CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      err_cnt_q <= '0;
    end else if (out_valid_q && out_ready && mism_q && (err_cnt_q != CNT_MAX)) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign err_cnt   = err_cnt_q;

endmodule
